// File: rtl/instruction_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch front end and the decode stage.
//   - fetch_state_e : fetch controller state encoding
//   - if_id_t       : IF/ID pipeline bundle {pc, instruction, valid}
//   - RESET_PC_DEFAULT, IF_ADDR_WIDTH : default reset vector and address width
//   - next_word_addr / align_word : word-address helpers
package instruction_fetch_stage_pkg;

    localparam int unsigned IF_ADDR_WIDTH = 32;
    localparam logic [IF_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [IF_ADDR_WIDTH-1:0] pc;
        logic [31:0]              instruction;
        logic                     valid;
    } if_id_t;

    // Sequential word address; wraps modulo 2^IF_ADDR_WIDTH.
    function automatic logic [IF_ADDR_WIDTH-1:0] next_word_addr(input logic [IF_ADDR_WIDTH-1:0] addr);
        return addr + 32'd4;
    endfunction

    // Force an address onto a word boundary.
    function automatic logic [IF_ADDR_WIDTH-1:0] align_word(input logic [IF_ADDR_WIDTH-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears the bundle
//   load_i  : capture data_i
//   flush_i : clear to a bubble (wins over load_i)
//   data_i  : incoming IF/ID bundle
//   data_o  : registered IF/ID bundle
// With neither load_i nor flush_i the register holds its contents.
module instruction_fetch_stage_if_id_register
    import instruction_fetch_stage_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  logic   flush_i,
    input  if_id_t data_i,
    output if_id_t data_o
);

    if_id_t bundle_q;

    // Bundle storage: flush beats load, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bundle_q <= '0;
        end else if (flush_i) begin
            bundle_q <= '0;
        end else if (load_i) begin
            bundle_q <= data_i;
        end else begin
            bundle_q <= bundle_q;
        end
    end

    assign data_o = bundle_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage of the 5-stage ARM pipeline.
// Owns the PC, issues word fetches over a req/ready handshake, and feeds the
// decode stage through the IF/ID register. A one-entry skid buffer absorbs a
// response that lands while the pipe is frozen; a DISCARD state swallows the
// response of a request that was outstanding when a branch redirected.
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   freeze         : hazard stall, hold PC and IF/ID
//   branchTaken    : single-cycle redirect pulse from EX (beats freeze)
//   branchAddr     : redirect target, low two bits ignored
//   imemReq        : fetch request (registered)
//   imemAddr       : fetch address, stable while a request is outstanding
//   imemRdata      : fetched word, valid when imemReady=1
//   imemReady      : one-cycle response strobe
//   pcOut          : IF/ID fetched address + 4
//   instructionOut : IF/ID instruction word
//   validOut       : IF/ID valid (0 = bubble)
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = IF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = RESET_PC_DEFAULT
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] branchAddr,
    output logic                  imemReq,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    input  logic [31:0]           imemRdata,
    input  logic                  imemReady,
    output logic [ADDR_WIDTH-1:0] pcOut,
    output logic [31:0]           instructionOut,
    output logic                  validOut
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_q, req_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
    logic [31:0]           skid_data_q, skid_data_d;

    logic                  resp_s;
    logic [ADDR_WIDTH-1:0] branch_tgt_s;
    logic                  ifid_load_s;
    logic                  ifid_flush_s;
    if_id_t                ifid_data_s;
    if_id_t                ifid_out_s;

    // A strobe only counts while our request is actually on the bus; this
    // also ignores anything seen in the first cycle after reset release.
    assign resp_s       = req_q & imemReady;
    assign branch_tgt_s = align_word(branchAddr);

    // Next-state, PC, skid and IF/ID control decode.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        ifid_load_s  = 1'b0;
        ifid_flush_s = 1'b0;
        ifid_data_s  = '{pc: next_word_addr(req_addr_q), instruction: imemRdata, valid: 1'b1};

        if (branchTaken) begin
            ifid_flush_s = 1'b1;
            skid_valid_d = 1'b0;
            pc_d         = branch_tgt_s;
            // An outstanding request keeps its address; its response is
            // swallowed in DISCARD before the target is fetched.
            if (((state_q == FETCH) && req_q && !imemReady) ||
                ((state_q == DISCARD) && !imemReady)) begin
                state_d = DISCARD;
            end else begin
                state_d    = FETCH;
                req_addr_d = branch_tgt_s;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (resp_s && freeze) begin
                        skid_valid_d = 1'b1;
                        skid_addr_d  = req_addr_q;
                        skid_data_d  = imemRdata;
                        state_d      = HOLD;
                    end else if (resp_s) begin
                        ifid_load_s = 1'b1;
                        pc_d        = next_word_addr(req_addr_q);
                        req_addr_d  = next_word_addr(req_addr_q);
                        state_d     = FETCH;
                    end else begin
                        state_d = FETCH;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        ifid_load_s  = 1'b1;
                        ifid_data_s  = '{pc: next_word_addr(skid_addr_q), instruction: skid_data_q, valid: 1'b1};
                        pc_d         = next_word_addr(skid_addr_q);
                        req_addr_d   = next_word_addr(skid_addr_q);
                        skid_valid_d = 1'b0;
                        state_d      = FETCH;
                    end else begin
                        state_d = HOLD;
                    end
                end
                DISCARD: begin
                    if (resp_s) begin
                        req_addr_d = pc_q;
                        state_d    = FETCH;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                default: begin
                    skid_valid_d = 1'b0;
                    req_addr_d   = pc_q;
                    state_d      = FETCH;
                end
            endcase
        end

        // Request is registered: it follows the state being entered.
        if (state_d == HOLD) begin
            req_d = 1'b0;
        end else begin
            req_d = 1'b1;
        end
    end

    // Fetch controller registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            req_q        <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            req_q        <= req_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
        end
    end

    instruction_fetch_stage_if_id_register u_if_id (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (ifid_load_s),
        .flush_i (ifid_flush_s),
        .data_i  (ifid_data_s),
        .data_o  (ifid_out_s)
    );

    assign imemReq        = req_q;
    assign imemAddr       = req_addr_q;
    assign pcOut          = ifid_out_s.pc;
    assign instructionOut = ifid_out_s.instruction;
    assign validOut       = ifid_out_s.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage. A behavioural memory
// answers requests after a configurable latency; delivered instructions are
// checked against a program-order stream model (next expected address,
// redirected by branches).
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchAddr = 32'h0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata = 32'h0;
    logic        imemReady = 1'b0;
    logic [31:0] pcOut;
    logic [31:0] instructionOut;
    logic        validOut;

    logic        w_imemReq;
    logic [31:0] w_imemAddr;
    logic [31:0] w_imemRdata = 32'h0;
    logic        w_imemReady = 1'b0;
    logic [31:0] w_pcOut;
    logic [31:0] w_instructionOut;
    logic        w_validOut;

    instruction_fetch_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken), .branchAddr(branchAddr),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemRdata(imemRdata), .imemReady(imemReady),
        .pcOut(pcOut), .instructionOut(instructionOut), .validOut(validOut)
    );

    instruction_fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken), .branchAddr(branchAddr),
        .imemReq(w_imemReq), .imemAddr(w_imemAddr), .imemRdata(w_imemRdata), .imemReady(w_imemReady),
        .pcOut(w_pcOut), .instructionOut(w_instructionOut), .validOut(w_validOut)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    int mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] req_log[$];
    logic [31:0] dpc_log[$];
    logic [31:0] dins_log[$];
    logic        last_valid = 1'b0;
    logic [31:0] last_pc = 32'h0;
    int first_ready_cyc = -1;
    int first_valid_cyc = -1;

    // Memory contents: distinct word per address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hE3A0_1001 + (a << 4);
    endfunction

    // Behavioural memory: answers each request after mem_lat extra cycles.
    task automatic mem_update();
        if (!rst) begin
            mem_cnt = 0; imemReady = 1'b0; imemRdata = 32'hDEAD_BEEF;
        end else if (!imemReq) begin
            mem_cnt = 0; imemReady = 1'b0; imemRdata = 32'hDEAD_BEEF;
        end else begin
            if (mem_cnt == 0) begin
                mem_addr = imemAddr;
                req_log.push_back(imemAddr);
            end else begin
                n_checks++;
                if (imemAddr !== mem_addr) $display("FAIL addr_stable: got %h expected %h", imemAddr, mem_addr);
                else n_pass++;
            end
            if (mem_cnt >= mem_lat) begin
                imemReady = 1'b1; imemRdata = word_at(mem_addr); mem_cnt = 0;
                if (first_ready_cyc < 0) first_ready_cyc = cyc;
            end else begin
                imemReady = 1'b0; imemRdata = 32'hDEAD_BEEF; mem_cnt++;
            end
        end
    endtask

    // Records each new instruction presented on IF/ID.
    task automatic monitor();
        if (validOut && (!last_valid || pcOut !== last_pc)) begin
            dpc_log.push_back(pcOut);
            dins_log.push_back(instructionOut);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        last_valid = validOut;
        last_pc    = pcOut;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        mem_update();
        monitor();
    endtask

    task automatic apply_reset(input int lat);
        rst = 1'b0; freeze = 1'b0; branchTaken = 1'b0; branchAddr = 32'h0;
        w_imemReady = 1'b0; w_imemRdata = 32'h0;
        mem_lat = lat; mem_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        req_log.delete(); dpc_log.delete(); dins_log.delete();
        last_valid = 1'b0; last_pc = 32'h0;
        first_ready_cyc = -1; first_valid_cyc = -1; cyc = 0;
        rst = 1'b1;
        mem_update();
        monitor();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({validOut, pcOut, instructionOut, imemReq, imemAddr} !== 98'b0)
            $display("FAIL reset_outputs: got v=%b pc=%h ins=%h req=%b addr=%h expected all 0", validOut, pcOut, instructionOut, imemReq, imemAddr);
        else n_pass++;
        n_checks++;
        if (w_imemAddr !== 32'hFFFF_FFFC) $display("FAIL reset_pc_param: got %h expected fffffffc", w_imemAddr);
        else n_pass++;
        apply_reset(1);
        n_checks++;
        if (imemReq !== 1'b0) $display("FAIL req_before_edge: got %b expected 0", imemReq);
        else n_pass++;
        tick();
        n_checks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0) $display("FAIL first_request: got req=%b addr=%h expected 1/0", imemReq, imemAddr);
        else n_pass++;
    endtask

    task automatic test_straight_line();
        apply_reset(1);
        for (int i = 0; i < 40 && dpc_log.size() < 3; i++) tick();
        n_checks++;
        if (dpc_log.size() < 3 || req_log.size() < 3) $display("FAIL straight_count: got %0d deliveries expected 3", dpc_log.size());
        else n_pass++;
        if (dpc_log.size() >= 3 && req_log.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (req_log[k] !== 32'(4 * k) || dpc_log[k] !== 32'(4 * k + 4) || dins_log[k] !== word_at(32'(4 * k)))
                    $display("FAIL straight_%0d: got addr=%h pc=%h ins=%h expected %h/%h/%h", k, req_log[k], dpc_log[k], dins_log[k], 32'(4 * k), 32'(4 * k + 4), word_at(32'(4 * k)));
                else n_pass++;
            end
        end
        n_checks++;
        if (first_valid_cyc != first_ready_cyc + 1) $display("FAIL valid_latency: got cycle %0d expected %0d", first_valid_cyc, first_ready_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_freeze_skid();
        bit found = 1'b0;
        apply_reset(1);
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imemReady && imemAddr == 32'h8) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL skid_setup: got no ready for 00000008 expected one");
        else n_pass++;
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (imemReq !== 1'b0 || pcOut !== 32'h8 || validOut !== 1'b1)
                $display("FAIL skid_hold_%0d: got req=%b pc=%h v=%b expected 0/00000008/1", i, imemReq, pcOut, validOut);
            else n_pass++;
        end
        freeze = 1'b0;
        tick();
        n_checks++;
        if (pcOut !== 32'hC || instructionOut !== word_at(32'h8) || imemReq !== 1'b1 || imemAddr !== 32'hC)
            $display("FAIL skid_release: got pc=%h ins=%h req=%b addr=%h expected 0000000c/%h/1/0000000c", pcOut, instructionOut, imemReq, imemAddr, word_at(32'h8));
        else n_pass++;
        for (int i = 0; i < 20 && dpc_log.size() < 4; i++) tick();
        n_checks++;
        if (dpc_log.size() != 4) $display("FAIL skid_sequence_len: got %0d expected 4", dpc_log.size());
        else n_pass++;
        if (dpc_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (dpc_log[k] !== 32'(4 * k + 4) || dins_log[k] !== word_at(32'(4 * k)))
                    $display("FAIL skid_seq_%0d: got pc=%h ins=%h expected %h/%h", k, dpc_log[k], dins_log[k], 32'(4 * k + 4), word_at(32'(4 * k)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_branch_outstanding();
        bit found = 1'b0;
        bit saw_ready = 1'b0;
        int n_before;
        apply_reset(3);
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (imemReq && imemAddr == 32'h10 && mem_cnt == 1 && !imemReady) found = 1'b1;
        end
        n_checks++;
        if (!found || validOut !== 1'b1) $display("FAIL br_setup: got found=%b v=%b expected 1/1", found, validOut);
        else n_pass++;
        n_before = dpc_log.size();
        branchTaken = 1'b1; branchAddr = 32'h100;
        tick();
        branchTaken = 1'b0;
        n_checks++;
        if (validOut !== 1'b0 || pcOut !== 32'h0 || instructionOut !== 32'h0 || imemAddr !== 32'h10 || imemReq !== 1'b1)
            $display("FAIL br_flush: got v=%b pc=%h ins=%h addr=%h req=%b expected 0/0/0/00000010/1", validOut, pcOut, instructionOut, imemAddr, imemReq);
        else n_pass++;
        for (int i = 0; i < 10 && !saw_ready; i++) begin
            if (imemReady) saw_ready = 1'b1;
            else tick();
            n_checks++;
            if (imemAddr !== 32'h10 || validOut !== 1'b0) $display("FAIL br_pending: got addr=%h v=%b expected 00000010/0", imemAddr, validOut);
            else n_pass++;
        end
        n_checks++;
        if (!saw_ready) $display("FAIL br_stale_timeout: got no stale response expected one");
        else n_pass++;
        tick();
        n_checks++;
        if (imemAddr !== 32'h100 || imemReq !== 1'b1 || validOut !== 1'b0)
            $display("FAIL br_redirect: got addr=%h req=%b v=%b expected 00000100/1/0", imemAddr, imemReq, validOut);
        else n_pass++;
        for (int i = 0; i < 20 && dpc_log.size() <= n_before; i++) tick();
        n_checks++;
        if (dpc_log.size() != n_before + 1 || dpc_log[$] !== 32'h104 || dins_log[$] !== word_at(32'h100))
            $display("FAIL br_target: got n=%0d pc=%h ins=%h expected %0d/00000104/%h", dpc_log.size(), dpc_log[$], dins_log[$], n_before + 1, word_at(32'h100));
        else n_pass++;
    endtask

    task automatic test_branch_freeze_hold();
        bit found = 1'b0;
        int n_before;
        apply_reset(1);
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (imemReady && imemAddr == 32'h8) found = 1'b1;
        end
        freeze = 1'b1;
        tick(); tick();
        n_checks++;
        if (!found || imemReq !== 1'b0) $display("FAIL bf_setup: got found=%b req=%b expected 1/0", found, imemReq);
        else n_pass++;
        n_before = dpc_log.size();
        branchTaken = 1'b1; branchAddr = 32'h203;
        tick();
        branchTaken = 1'b0;
        n_checks++;
        if (validOut !== 1'b0 || pcOut !== 32'h0 || instructionOut !== 32'h0 || imemReq !== 1'b1 || imemAddr !== 32'h200)
            $display("FAIL bf_flush: got v=%b pc=%h ins=%h req=%b addr=%h expected 0/0/0/1/00000200", validOut, pcOut, instructionOut, imemReq, imemAddr);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (validOut !== 1'b0) $display("FAIL bf_frozen_bubble: got v=%b expected 0", validOut);
        else n_pass++;
        freeze = 1'b0;
        for (int i = 0; i < 20 && dpc_log.size() <= n_before; i++) tick();
        n_checks++;
        if (dpc_log.size() != n_before + 1 || dpc_log[$] !== 32'h204 || dins_log[$] !== word_at(32'h200))
            $display("FAIL bf_target: got n=%0d pc=%h ins=%h expected %0d/00000204/%h", dpc_log.size(), dpc_log[$], dins_log[$], n_before + 1, word_at(32'h200));
        else n_pass++;
    endtask

    task automatic test_async_reset_discard();
        bit found = 1'b0;
        apply_reset(3);
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (imemReq && imemAddr == 32'h8 && mem_cnt == 1 && !imemReady) found = 1'b1;
        end
        branchTaken = 1'b1; branchAddr = 32'h40;
        tick();
        branchTaken = 1'b0;
        tick();
        n_checks++;
        if (!found || imemReq !== 1'b1 || imemAddr !== 32'h8) $display("FAIL ar_setup: got found=%b req=%b addr=%h expected 1/1/00000008", found, imemReq, imemAddr);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({validOut, pcOut, instructionOut, imemReq, imemAddr} !== 98'b0)
            $display("FAIL ar_immediate: got v=%b pc=%h ins=%h req=%b addr=%h expected all 0", validOut, pcOut, instructionOut, imemReq, imemAddr);
        else n_pass++;
        mem_update();
        @(posedge clk); #1;
        rst = 1'b1;
        imemReady = 1'b1; imemRdata = 32'hBAD0_0BAD;
        dpc_log.delete(); dins_log.delete(); last_valid = 1'b0; last_pc = 32'h0;
        tick();
        n_checks++;
        if (validOut !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h0)
            $display("FAIL ar_restart: got v=%b req=%b addr=%h expected 0/1/00000000", validOut, imemReq, imemAddr);
        else n_pass++;
        for (int i = 0; i < 20 && dpc_log.size() < 1; i++) tick();
        n_checks++;
        if (dpc_log.size() < 1 || dpc_log[0] !== 32'h4 || dins_log[0] !== word_at(32'h0))
            $display("FAIL ar_first: got n=%0d pc=%h expected 1/00000004", dpc_log.size(), pcOut);
        else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset(1);
        tick();
        n_checks++;
        if (w_imemReq !== 1'b1 || w_imemAddr !== 32'hFFFF_FFFC || w_validOut !== 1'b0)
            $display("FAIL wrap_first_req: got req=%b addr=%h v=%b expected 1/fffffffc/0", w_imemReq, w_imemAddr, w_validOut);
        else n_pass++;
        w_imemReady = 1'b1; w_imemRdata = word_at(32'hFFFF_FFFC);
        tick();
        w_imemReady = 1'b0;
        n_checks++;
        if (w_validOut !== 1'b1 || w_pcOut !== 32'h0 || w_instructionOut !== word_at(32'hFFFF_FFFC) || w_imemAddr !== 32'h0 || w_imemReq !== 1'b1)
            $display("FAIL wrap_result: got v=%b pc=%h ins=%h addr=%h req=%b expected 1/0/%h/0/1", w_validOut, w_pcOut, w_instructionOut, w_imemAddr, w_imemReq, word_at(32'hFFFF_FFFC));
        else n_pass++;
    endtask

    task automatic test_random();
        for (int seg = 1; seg <= 3; seg++) begin
            logic [31:0] exp_pc;
            logic [31:0] s_pc, s_ins, tgt;
            logic        s_val, pf, pb;
            int          ndel = 0;
            apply_reset(seg);
            exp_pc = 32'h0;
            for (int c = 0; c < 300; c++) begin
                freeze = ($urandom_range(0, 2) == 0);
                branchTaken = ($urandom_range(0, 14) == 0);
                tgt = $urandom();
                if (tgt[0]) tgt = 32'hFFFF_FFF0 + (tgt & 32'hF);
                else tgt = tgt & 32'h0000_0FFF;
                branchAddr = tgt;
                s_pc = pcOut; s_ins = instructionOut; s_val = validOut;
                pf = freeze; pb = branchTaken;
                tick();
                branchTaken = 1'b0;
                if (pb) begin
                    exp_pc = tgt & 32'hFFFF_FFFC;
                    n_checks++;
                    if ({validOut, pcOut, instructionOut} !== 65'b0)
                        $display("FAIL rnd_flush: got v=%b pc=%h ins=%h expected 0/0/0", validOut, pcOut, instructionOut);
                    else n_pass++;
                end else if (pf) begin
                    n_checks++;
                    if ({validOut, pcOut, instructionOut} !== {s_val, s_pc, s_ins})
                        $display("FAIL rnd_freeze_hold: got v=%b pc=%h ins=%h expected %b/%h/%h", validOut, pcOut, instructionOut, s_val, s_pc, s_ins);
                    else n_pass++;
                end
                if (validOut && (!s_val || pcOut !== s_pc)) begin
                    n_checks++;
                    if (pcOut !== exp_pc + 32'd4 || instructionOut !== word_at(exp_pc))
                        $display("FAIL rnd_stream: got pc=%h ins=%h expected %h/%h", pcOut, instructionOut, exp_pc + 32'd4, word_at(exp_pc));
                    else n_pass++;
                    exp_pc = exp_pc + 32'd4;
                    ndel++;
                end
            end
            n_checks++;
            if (ndel < 10) $display("FAIL rnd_progress: got %0d deliveries expected at least 10", ndel);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_freeze_skid();
        test_branch_outstanding();
        test_branch_freeze_hold();
        test_async_reset_discard();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Front end of the 5-stage ARM pipeline. It owns the program counter, issues word fetches to an instruction memory over a req/ready handshake, and drives the IF/ID pipeline register that feeds the decode stage. It honours the hazard unit's freeze and the execute stage's branch redirect, using a one-entry skid buffer and a discard state so that no instruction is lost or duplicated.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
ADDR_WIDTH, 32, PC / instruction address width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
freeze  in  1  hazard stall; hold PC and IF/ID register
branchTaken  in  1  redirect request from EX (single-cycle pulse)
branchAddr  in  ADDR_WIDTH  redirect target
imemReq  out  1  fetch request
imemAddr  out  ADDR_WIDTH  fetch address, word aligned
imemRdata  in  32  fetched instruction word
imemReady  in  1  one-cycle response strobe; imemRdata valid in that cycle
pcOut  out  ADDR_WIDTH  IF/ID: fetched address + 4
instructionOut  out  32  IF/ID: instruction word
validOut  out  1  IF/ID: instruction valid (0 = bubble)

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, reqAddr=RESET_PC, state=FETCH, skid empty, pcOut=0, instructionOut=0, validOut=0. imemReq=1 from the first edge after release.
- State machine:
  - FETCH: imemReq=1 and imemAddr=reqAddr.
  - HOLD: skid full, imemReq=0.
  - DISCARD: imemReq=1, waiting for a stale response.
- Request rule: while imemReq=1, imemAddr stays stable until imemReady. Branches never change the address of an outstanding request.
- FETCH, imemReady=1, freeze=0, branchTaken=0: the IF/ID register loads {reqAddr+4, imemRdata, valid=1}; pc and reqAddr advance by 4; stay in FETCH. A new request issues the next cycle.
  - Latency: ready in cycle N gives IF/ID outputs visible from cycle N+1.
- FETCH, imemReady=1, freeze=1: imemRdata and its address go into the skid; go to HOLD. The IF/ID register holds.
- FETCH, imemReady=0: no change. Freeze alone does not drop imemReq.
- HOLD, freeze=0: the skid moves into IF/ID (valid=1), pc and reqAddr advance by 4, skid empties, go to FETCH.
- HOLD, freeze=1: everything holds.
- freeze=1 with no new data: IF/ID outputs (including validOut) hold their values.
- branchTaken=1, in any state, has priority over freeze:
  - IF/ID cleared: validOut=0, instructionOut=0, pcOut=0.
  - Skid emptied; pc and reqAddr set to branchAddr.
  - Next state is DISCARD if in FETCH with imemReady=0 (outstanding request). Otherwise FETCH: response consumed this cycle is dropped, or the request came from HOLD/DISCARD.
  - In DISCARD, reqAddr stays at the old address until the stale response arrives; the branch target is latched in pc.
- DISCARD:
  - imemReady=1: drop data, set reqAddr=pc, go to FETCH.
  - branchTaken again: update pc only.
- Address arithmetic: +4 is modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC wraps to 0. branchAddr[1:0] are ignored and forced to 00.
- Reset mid-fetch: state and outputs return to reset values immediately. Any response that arrives later is ignored (the memory is reset by the same rst).

Decomposition:
- Shared pipeline package holds:
  - the fetch state encoding (FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2);
  - the RESET_PC constant;
  - an IF/ID bundle typedef {pc, instruction, valid}, reused by the decode stage.
- One natural sub-module: if_id_register. It is a clocked bundle with load, flush and hold controls and async active-low reset; the stage instantiates it. FSM, PC and skid stay in the top.

Test Plan:
- Straight-line: memory returns ready one cycle after each request, words 0xE3A01001… at 0,4,8. Required:
  - imemAddr sequences 0,4,8;
  - pcOut sequences 4,8,12 with matching instructionOut;
  - validOut=1 from the cycle after the first ready.
- Freeze with skid: assert freeze in the cycle ready returns addr 8. Required:
  - IF/ID holds pcOut=8; imemReq=0 while frozen;
  - on release, pcOut=12 with the word from 8; next fetch is 12; no duplicate or skipped word.
- Branch with outstanding fetch (3-cycle memory latency): branchTaken with branchAddr=0x100 while addr 0x10 is pending. Required:
  - validOut=0 next cycle; imemAddr stays 0x10 until ready;
  - 0x10 data is never presented; next request is 0x100; then pcOut=0x104.
- Branch + freeze same cycle, while in HOLD: required flush (validOut=0), skid dropped, fetch restarts at branchAddr even with freeze still high.
- Wrap: RESET_PC=32'hFFFF_FFFC. Required: first pcOut=0, second fetch address=0.
- Async reset mid-DISCARD: drop rst to 0 between clock edges. Required: outputs become 0 immediately; after release, first imemAddr=RESET_PC and the late stale ready is ignored.
